// File: rtl/arcade_input_pkg.sv
// Shared definitions for arcade_input_mux: joystick bit layout, rotation and
// sequencer enums, PS/2 scancodes, keyboard key map and decode helpers.
// Optional feature macro used by the top: ARCADE_INPUT_AUTOFIRE_EN.
package arcade_input_pkg;

  // Joystick word layout (16 bits per player)
  localparam int unsigned JOY_W   = 16;
  localparam int unsigned JOY_R   = 0;
  localparam int unsigned JOY_L   = 1;
  localparam int unsigned JOY_D   = 2;
  localparam int unsigned JOY_U   = 3;
  localparam int unsigned JOY_BTN = 4;

  typedef enum logic [1:0] {
    ROT_0     = 2'd0,
    ROT_CW90  = 2'd1,
    ROT_180   = 2'd2,
    ROT_CCW90 = 2'd3
  } rot_e;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_COIN,
    SEQ_GAP,
    SEQ_START,
    SEQ_RELEASE
  } seq_state_e;

  // PS/2 set-2 scancodes, bit 8 = E0 extended prefix
  localparam logic [8:0] SC_UP     = 9'h075;
  localparam logic [8:0] SC_DOWN   = 9'h072;
  localparam logic [8:0] SC_LEFT   = 9'h06B;
  localparam logic [8:0] SC_RIGHT  = 9'h074;
  localparam logic [8:0] SC_CTRL   = 9'h014;
  localparam logic [8:0] SC_SPACE  = 9'h029;
  localparam logic [8:0] SC_ALT    = 9'h011;
  localparam logic [8:0] SC_LSHIFT = 9'h012;
  localparam logic [8:0] SC_F1     = 9'h005;
  localparam logic [8:0] SC_5      = 9'h02E;
  localparam logic [8:0] SC_R      = 9'h02D;
  localparam logic [8:0] SC_F      = 9'h02B;
  localparam logic [8:0] SC_D      = 9'h023;
  localparam logic [8:0] SC_G      = 9'h034;
  localparam logic [8:0] SC_A      = 9'h01C;
  localparam logic [8:0] SC_S      = 9'h01B;
  localparam logic [8:0] SC_Q      = 9'h015;
  localparam logic [8:0] SC_F2     = 9'h006;
  localparam logic [8:0] SC_6      = 9'h036;

  // One held-state register per mapped key
  localparam int unsigned K_UP     = 0;
  localparam int unsigned K_DOWN   = 1;
  localparam int unsigned K_LEFT   = 2;
  localparam int unsigned K_RIGHT  = 3;
  localparam int unsigned K_CTRL   = 4;
  localparam int unsigned K_SPACE  = 5;
  localparam int unsigned K_ALT    = 6;
  localparam int unsigned K_LSHIFT = 7;
  localparam int unsigned K_F1     = 8;
  localparam int unsigned K_5      = 9;
  localparam int unsigned K_R      = 10;
  localparam int unsigned K_F      = 11;
  localparam int unsigned K_D      = 12;
  localparam int unsigned K_G      = 13;
  localparam int unsigned K_A      = 14;
  localparam int unsigned K_S      = 15;
  localparam int unsigned K_Q      = 16;
  localparam int unsigned K_F2     = 17;
  localparam int unsigned K_6      = 18;
  localparam int unsigned NKEYS    = 19;

  localparam int unsigned KB_BTNS = 3;

  // Keyboard contribution for one player
  typedef struct packed {
    logic [3:0]         dir;   // {U,D,L,R}
    logic [KB_BTNS-1:0] btn;
    logic               start;
    logic               coin;
  } kb_ctrl_t;

  // One-hot-ish match of a scancode against the key map; arrows ignore E0
  function automatic logic [NKEYS-1:0] kb_decode(input logic [8:0] code);
    logic [NKEYS-1:0] hit;
    hit           = '0;
    hit[K_UP]     = (code[7:0] == SC_UP[7:0]);
    hit[K_DOWN]   = (code[7:0] == SC_DOWN[7:0]);
    hit[K_LEFT]   = (code[7:0] == SC_LEFT[7:0]);
    hit[K_RIGHT]  = (code[7:0] == SC_RIGHT[7:0]);
    hit[K_CTRL]   = (code == SC_CTRL);
    hit[K_SPACE]  = (code == SC_SPACE);
    hit[K_ALT]    = (code == SC_ALT);
    hit[K_LSHIFT] = (code == SC_LSHIFT);
    hit[K_F1]     = (code == SC_F1);
    hit[K_5]      = (code == SC_5);
    hit[K_R]      = (code == SC_R);
    hit[K_F]      = (code == SC_F);
    hit[K_D]      = (code == SC_D);
    hit[K_G]      = (code == SC_G);
    hit[K_A]      = (code == SC_A);
    hit[K_S]      = (code == SC_S);
    hit[K_Q]      = (code == SC_Q);
    hit[K_F2]     = (code == SC_F2);
    hit[K_6]      = (code == SC_6);
    return hit;
  endfunction

  function automatic kb_ctrl_t kb_player(input logic [NKEYS-1:0] k, input logic p1);
    kb_ctrl_t c;
    if (p1) begin
      c.dir   = {k[K_R], k[K_F], k[K_D], k[K_G]};
      c.btn   = {k[K_Q], k[K_S], k[K_A]};
      c.start = k[K_F2];
      c.coin  = k[K_6];
    end else begin
      c.dir   = {k[K_UP], k[K_DOWN], k[K_LEFT], k[K_RIGHT]};
      c.btn   = {k[K_LSHIFT], k[K_ALT], k[K_CTRL] | k[K_SPACE]};
      c.start = k[K_F1];
      c.coin  = k[K_5];
    end
    return c;
  endfunction

  // d and result are {U,D,L,R}
  function automatic logic [3:0] rotate_dir(input logic [3:0] d, input rot_e r);
    case (r)
      ROT_CW90:  return {d[1], d[0], d[2], d[3]};
      ROT_180:   return {d[2], d[3], d[0], d[1]};
      ROT_CCW90: return {d[0], d[1], d[3], d[2]};
      default:   return d;
    endcase
  endfunction

endpackage

// File: rtl/arcade_coin_seq.sv
// Per-player coin/start sequencer: turns coin/start presses into timed
// pulses, optionally a coin pulse followed by a start pulse.
// Ports: clk, rst_n (async active-low), coin_auto, raw_coin, raw_start in;
//        coin, start registered pulse outputs.
module arcade_coin_seq
  import arcade_input_pkg::*;
#(
  parameter int unsigned COIN_PULSE = 2457600
) (
  input  logic clk,
  input  logic rst_n,
  input  logic coin_auto,
  input  logic raw_coin,
  input  logic raw_start,
  output logic coin,
  output logic start
);

  localparam int unsigned   CW   = $clog2(COIN_PULSE + 1);
  localparam logic [CW-1:0] LOAD = CW'(COIN_PULSE - 1);

  seq_state_e    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          auto_q, auto_d;
  logic          coin_q, start_q;
  logic          coin_d, start_d;
  logic          coin_rise, start_rise, last;

  // State, counter, edge and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SEQ_IDLE;
      cnt     <= '0;
      auto_q  <= 1'b0;
      coin_q  <= 1'b0;
      start_q <= 1'b0;
      coin    <= 1'b0;
      start   <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      auto_q  <= auto_d;
      coin_q  <= raw_coin;
      start_q <= raw_start;
      coin    <= coin_d;
      start   <= start_d;
    end
  end

  // Next state and next outputs; each timed phase lasts COIN_PULSE cycles
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    auto_d     = auto_q;
    coin_d     = 1'b0;
    start_d    = 1'b0;
    coin_rise  = raw_coin & ~coin_q;
    start_rise = raw_start & ~start_q;
    last       = (cnt == '0);
    case (state)
      SEQ_IDLE: begin
        if (coin_rise) begin
          state_d = SEQ_COIN;
          cnt_d   = LOAD;
          auto_d  = coin_auto & start_rise;
          coin_d  = 1'b1;
        end else if (start_rise && coin_auto) begin
          state_d = SEQ_COIN;
          cnt_d   = LOAD;
          auto_d  = 1'b1;
          coin_d  = 1'b1;
        end else begin
          start_d = raw_start & ~coin_auto;
        end
      end
      SEQ_COIN: begin
        if (last) begin
          state_d = auto_q ? SEQ_GAP : SEQ_RELEASE;
          cnt_d   = LOAD;
        end else begin
          cnt_d  = cnt - CW'(1);
          coin_d = 1'b1;
        end
      end
      SEQ_GAP: begin
        if (last) begin
          state_d = SEQ_START;
          cnt_d   = LOAD;
          start_d = 1'b1;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      SEQ_START: begin
        if (last) begin
          state_d = SEQ_RELEASE;
          auto_d  = 1'b0;
        end else begin
          cnt_d   = cnt - CW'(1);
          start_d = 1'b1;
        end
      end
      SEQ_RELEASE: begin
        if (!raw_coin && !raw_start) state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

endmodule

// File: rtl/arcade_input_mux.sv
// Merges PS/2 keyboard and MiSTer joysticks into per-player arcade controls
// with direction rotation and timed coin/start sequencing.
// Ports: clk_sys, I_RESETn (async active-low), ps2_key, joy_in (16b/player),
//        merge, rotate, coin_auto in; o_dir {U,D,L,R}, o_btn, o_start, o_coin
//        registered active-high outputs.
// Optional: ARCADE_INPUT_AUTOFIRE_EN adds the autofire input and divider.
module arcade_input_mux
  import arcade_input_pkg::*;
#(
  parameter int unsigned PLAYERS      = 2,
  parameter int unsigned BUTTONS      = 3,
  parameter int unsigned COIN_PULSE   = 2457600,
  parameter int unsigned AUTOFIRE_DIV = 1228800
) (
  input  logic                       clk_sys,
  input  logic                       I_RESETn,
  input  logic [10:0]                ps2_key,
  input  logic [PLAYERS*JOY_W-1:0]   joy_in,
  input  logic                       merge,
  input  logic [1:0]                 rotate,
  input  logic                       coin_auto,
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  input  logic [PLAYERS-1:0]         autofire,
`endif
  output logic [PLAYERS*4-1:0]       o_dir,
  output logic [PLAYERS*BUTTONS-1:0] o_btn,
  output logic [PLAYERS-1:0]         o_start,
  output logic [PLAYERS-1:0]         o_coin
);

  localparam int unsigned SEL_W   = JOY_BTN + BUTTONS + 2;
  localparam int unsigned J_START = JOY_BTN + BUTTONS;
  localparam int unsigned J_COIN  = JOY_BTN + BUTTONS + 1;

  logic             tog_q;
  logic [NKEYS-1:0] keys_q, key_hit;

  logic [SEL_W-1:0]   joy_or;
  logic [SEL_W-1:0]   joy_sel [PLAYERS];
  kb_ctrl_t           kb      [PLAYERS];
  logic [3:0]         raw_dir [PLAYERS];
  logic [BUTTONS-1:0] raw_btn [PLAYERS];
  logic [BUTTONS-1:0] btn_out [PLAYERS];
  logic [PLAYERS-1:0] raw_start, raw_coin;
  logic               unused_joy;

  always_comb key_hit = kb_decode(ps2_key[8:0]);

  // A toggle of ps2_key[10] marks a new key event
  always_ff @(posedge clk_sys or negedge I_RESETn) begin
    if (!I_RESETn) begin
      tog_q  <= 1'b0;
      keys_q <= '0;
    end else if (ps2_key[10] != tog_q) begin
      tog_q  <= ps2_key[10];
      keys_q <= (keys_q & ~key_hit) | (key_hit & {NKEYS{ps2_key[9]}});
    end
  end

  // Raw per-player controls: keyboard OR (own or merged) joystick
  always_comb begin
    unused_joy = ^joy_in;
    joy_or     = '0;
    for (int p = 0; p < PLAYERS; p++) joy_or |= joy_in[p*JOY_W +: SEL_W];
    for (int p = 0; p < PLAYERS; p++) begin
      joy_sel[p]   = merge ? joy_or : joy_in[p*JOY_W +: SEL_W];
      kb[p]        = (p < 2) ? kb_player(keys_q, p == 1) : '0;
      raw_dir[p]   = joy_sel[p][JOY_U:JOY_R] | kb[p].dir;
      raw_btn[p]   = joy_sel[p][JOY_BTN +: BUTTONS] | BUTTONS'(kb[p].btn);
      raw_start[p] = joy_sel[p][J_START] | kb[p].start;
      raw_coin[p]  = joy_sel[p][J_COIN] | kb[p].coin;
    end
  end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
  localparam int unsigned AF_W = $clog2(AUTOFIRE_DIV + 1);

  logic [AF_W-1:0]    af_cnt;
  logic               af_low;
  logic [PLAYERS-1:0] btn0_held;

  always_comb begin
    for (int p = 0; p < PLAYERS; p++) begin
      btn0_held[p] = raw_btn[p][0];
      btn_out[p]   = raw_btn[p];
      if (autofire[p]) btn_out[p][0] = raw_btn[p][0] & ~af_low;
    end
  end

  // Shared divider, parked (high phase) while nobody holds button0
  always_ff @(posedge clk_sys or negedge I_RESETn) begin
    if (!I_RESETn) begin
      af_cnt <= '0;
      af_low <= 1'b0;
    end else if (btn0_held == '0) begin
      af_cnt <= '0;
      af_low <= 1'b0;
    end else if (af_cnt == AF_W'(AUTOFIRE_DIV - 1)) begin
      af_cnt <= '0;
      af_low <= ~af_low;
    end else begin
      af_cnt <= af_cnt + AF_W'(1);
    end
  end
`else
  localparam int unsigned af_div_unused = AUTOFIRE_DIV;

  always_comb begin
    for (int p = 0; p < PLAYERS; p++) btn_out[p] = raw_btn[p];
  end
`endif

  // Direction and button output registers; rotation applied on the way in
  always_ff @(posedge clk_sys or negedge I_RESETn) begin
    if (!I_RESETn) begin
      o_dir <= '0;
      o_btn <= '0;
    end else begin
      for (int p = 0; p < PLAYERS; p++) begin
        o_dir[p*4 +: 4]             <= rotate_dir(raw_dir[p], rot_e'(rotate));
        o_btn[p*BUTTONS +: BUTTONS] <= btn_out[p];
      end
    end
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_seq
    arcade_coin_seq #(
      .COIN_PULSE(COIN_PULSE)
    ) u_seq (
      .clk       (clk_sys),
      .rst_n     (I_RESETn),
      .coin_auto (coin_auto),
      .raw_coin  (raw_coin[p]),
      .raw_start (raw_start[p]),
      .coin      (o_coin[p]),
      .start     (o_start[p])
    );
  end

endmodule

// File: tb/tb_arcade_input_mux.sv
// Scoreboard bench for arcade_input_mux (PLAYERS=2, BUTTONS=3, COIN_PULSE=4).
module tb_arcade_input_mux;

  localparam int unsigned CP = 4;
  localparam int NC = 27;

  logic        clk_sys = 1'b0;
  logic        I_RESETn;
  logic [10:0] ps2_key;
  logic [31:0] joy_in;
  logic        merge;
  logic [1:0]  rotate;
  logic        coin_auto;
  logic [7:0]  o_dir;
  logic [5:0]  o_btn;
  logic [1:0]  o_start;
  logic [1:0]  o_coin;

  arcade_input_mux #(
    .PLAYERS(2), .BUTTONS(3), .COIN_PULSE(CP), .AUTOFIRE_DIV(3)
  ) dut (
    .clk_sys   (clk_sys),
    .I_RESETn  (I_RESETn),
    .ps2_key   (ps2_key),
    .joy_in    (joy_in),
    .merge     (merge),
    .rotate    (rotate),
    .coin_auto (coin_auto),
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    .autofire  (2'b00),
`endif
    .o_dir     (o_dir),
    .o_btn     (o_btn),
    .o_start   (o_start),
    .o_coin    (o_coin)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [7:0] dir;
    logic [5:0] btn;
    logic [1:0] start;
    logic [1:0] coin;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // Reference model state
  bit   kdown [512];
  bit   seen_tog;
  bit   prc [2];
  bit   prs [2];
  int   mode [2];    // 0 idle, 1 busy (timed schedule), 2 waiting for release
  int   tt [2];
  bit   am [2];
  int   cbit [4] = '{3, 0, 2, 1};   // compass U,R,D,L -> bit in {U,D,L,R}
  logic [15:0] jheld [2];
  logic [8:0] codes [NC] = '{9'h075, 9'h072, 9'h06B, 9'h074, 9'h175, 9'h172, 9'h16B,
                            9'h174, 9'h014, 9'h029, 9'h011, 9'h012, 9'h005, 9'h02E,
                            9'h02D, 9'h02B, 9'h023, 9'h034, 9'h01C, 9'h01B, 9'h015,
                            9'h006, 9'h036, 9'h114, 9'h12D, 9'h01D, 9'h000};

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit kd(input int c);
    return kdown[c];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 512; i++) kdown[i] = 1'b0;
    seen_tog = 1'b0;
    for (int p = 0; p < 2; p++) begin
      prc[p] = 0; prs[p] = 0; mode[p] = 0; tt[p] = 0; am[p] = 0;
    end
  endtask

  // Expected outputs after the coming rising edge, from the current inputs
  task automatic model_step();
    exp_t        e;
    logic [15:0] jo, src;
    logic [3:0]  kdir, rawd, od;
    logic [2:0]  kbtn;
    logic [8:0]  c;
    bit          ks, kc, rs, rc, cr, sr;
    int          total;
    e = '0;
    if (!I_RESETn) begin
      model_reset();
      q.push_back(e);
      return;
    end
    jo = joy_in[15:0] | joy_in[31:16];
    for (int p = 0; p < 2; p++) begin
      src = merge ? jo : joy_in[p*16 +: 16];
      if (p == 0) begin
        kdir = {kd('h075), kd('h072), kd('h06B), kd('h074)};
        kbtn = {kd('h012), kd('h011), kd('h014) | kd('h029)};
        ks = kd('h005); kc = kd('h02E);
      end else begin
        kdir = {kd('h02D), kd('h02B), kd('h023), kd('h034)};
        kbtn = {kd('h015), kd('h01B), kd('h01C)};
        ks = kd('h006); kc = kd('h036);
      end
      rawd = src[3:0] | kdir;
      rs = src[7] | ks;
      rc = src[8] | kc;
      od = '0;
      for (int k = 0; k < 4; k++)
        if (rawd[cbit[k]]) od[cbit[(k + int'(rotate)) % 4]] = 1'b1;
      e.dir[p*4 +: 4] = od;
      e.btn[p*3 +: 3] = src[6:4] | kbtn;
      // Coin/start schedule
      if (mode[p] == 2) begin
        if (!rc && !rs) mode[p] = 0;
      end else begin
        if (mode[p] == 0) begin
          cr = rc && !prc[p];
          sr = rs && !prs[p];
          if (cr) begin
            mode[p] = 1; tt[p] = 0; am[p] = coin_auto && sr;
          end else if (sr && coin_auto) begin
            mode[p] = 1; tt[p] = 0; am[p] = 1;
          end else begin
            e.start[p] = rs && !coin_auto;
          end
        end
        if (mode[p] == 1) begin
          total = am[p] ? 3*CP + 1 : CP + 1;
          e.coin[p]  = (tt[p] < CP);
          e.start[p] = am[p] && (tt[p] >= 2*CP) && (tt[p] < 3*CP);
          tt[p]++;
          if (tt[p] == total) mode[p] = 2;
        end
      end
      prc[p] = rc;
      prs[p] = rs;
    end
    if (ps2_key[10] != seen_tog) begin
      seen_tog = ps2_key[10];
      c = ps2_key[8:0];
      if (c[7:0] == 8'h75 || c[7:0] == 8'h72 || c[7:0] == 8'h6B || c[7:0] == 8'h74) c[8] = 1'b0;
      kdown[c] = ps2_key[9];
    end
    q.push_back(e);
  endtask

  task automatic key(input logic [8:0] c, input logic pr);
    ps2_key = {~ps2_key[10], pr, c};
  endtask

  task automatic tick();
    model_step();
    @(negedge clk_sys);
  endtask

  task automatic rand_inputs();
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < 7; b++) if ($urandom_range(5) == 0) jheld[p][b] = ~jheld[p][b];
      for (int b = 7; b < 9; b++) if ($urandom_range(24) == 0) jheld[p][b] = ~jheld[p][b];
      jheld[p][15:9] = 7'($urandom);
    end
    joy_in = {jheld[1], jheld[0]};
    if ($urandom_range(39) == 0) merge = ~merge;
    if ($urandom_range(24) == 0) rotate = 2'($urandom);
    if ($urandom_range(59) == 0) coin_auto = ~coin_auto;
    if ($urandom_range(7) == 0) key(codes[$urandom_range(NC-1)], 1'($urandom_range(1)));
  endtask

  // Monitor: compare every registered output update with the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_sys);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("dir", 16'(o_dir), 16'(e.dir));
        chk("btn", 16'(o_btn), 16'(e.btn));
        chk("start", 16'(o_start), 16'(e.start));
        chk("coin", 16'(o_coin), 16'(e.coin));
      end
    end
  end

  initial begin
    int n0, n1;
    I_RESETn = 1'b0; ps2_key = '0; joy_in = '0; merge = 1'b0; rotate = '0; coin_auto = 1'b0;
    jheld[0] = '0; jheld[1] = '0;
    model_reset();
    repeat (2) @(negedge clk_sys);
    chk("reset_dir", 16'(o_dir), 16'h0);
    chk("reset_btn", 16'(o_btn), 16'h0);
    chk("reset_start", 16'(o_start), 16'h0);
    chk("reset_coin", 16'(o_coin), 16'h0);
    I_RESETn = 1'b1;

    // Directed patterns from the plan, checked through the scoreboard
    joy_in[3] = 1'b1; tick(); tick();
    rotate = 2'd1; joy_in = '0; joy_in[1] = 1'b1; tick(); tick();
    rotate = 2'd2; joy_in = '0; joy_in[3] = 1'b1; tick(); tick();
    rotate = 2'd0; joy_in = '0; key(9'h075, 1'b1); tick(); tick(); tick();
    key(9'h175, 1'b0); tick(); tick(); tick();
    merge = 1'b1; joy_in[16] = 1'b1; tick(); tick();
    merge = 1'b0; joy_in = '0; tick();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      tick();
    end

    // Quiesce: release all keys and joysticks
    jheld[0] = '0; jheld[1] = '0; joy_in = '0;
    merge = 1'b0; rotate = '0; coin_auto = 1'b0;
    for (int i = 0; i < NC; i++) begin
      key(codes[i], 1'b0);
      tick();
    end
    repeat (16) tick();

    // P1 coin held 20 cycles, plain coin
    n1 = 0;
    joy_in[24] = 1'b1;
    for (int i = 0; i < 26; i++) begin
      if (i == 20) joy_in[24] = 1'b0;
      tick();
      if (o_coin[1]) n1++;
    end
    chk("coin_pulse_len", 16'(n1), 16'(CP));

    // P0 start held with coin_auto: coin, gap, start, no retrigger
    n0 = 0; n1 = 0;
    coin_auto = 1'b1;
    joy_in[7] = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (o_coin[0]) n0++;
      if (o_start[0]) n1++;
    end
    chk("auto_coin_len", 16'(n0), 16'(CP));
    chk("auto_start_len", 16'(n1), 16'(CP));
    joy_in[7] = 1'b0;
    repeat (4) tick();

    // Reset in the middle of a coin pulse
    joy_in[7] = 1'b1;
    repeat (3) tick();
    chk("coin_before_reset", 16'(o_coin[0]), 16'h1);
    I_RESETn = 1'b0;
    #1;
    chk("reset_async_coin", 16'(o_coin), 16'h0);
    chk("reset_async_start", 16'(o_start), 16'h0);
    tick();
    joy_in[7] = 1'b0;
    tick();
    I_RESETn = 1'b1;
    repeat (3) tick();
    n0 = 0; n1 = 0;
    joy_in[7] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (o_coin[0]) n0++;
      if (o_start[0]) n1++;
    end
    chk("post_reset_coin_len", 16'(n0), 16'(CP));
    chk("post_reset_start_len", 16'(n1), 16'(CP));
    joy_in = '0;
    tick();

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk_sys);
    chk("scoreboard_drain", 16'(q.size()), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
